// File: rtl/my_matrix_multiplier_ctrl_master.sv
// AXI4-Lite master for the matrix multiplier control slave: writes the six kernel
// arguments, sets ap_start, polls AP_CTRL for ap_done and reports status/elapsed cycles.
module my_matrix_multiplier_ctrl_master #(
  parameter int C_ADDR_WIDTH    = 12,
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_POLL_INTERVAL = 16,
  parameter int C_MAX_POLLS     = 65535
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               nrows_A,
  input  logic [31:0]               ncols_A,
  input  logic [31:0]               ncols_B,
  input  logic [63:0]               in_A,
  input  logic [63:0]               in_B,
  input  logic [63:0]               out_C,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [31:0]               cycles,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [C_ADDR_WIDTH-1:0]   m_awaddr,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [C_DATA_WIDTH-1:0]   m_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [C_ADDR_WIDTH-1:0]   m_araddr,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [C_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp
);

  typedef enum logic [2:0] {IDLE, WR, BRESP, RD, RDATA, WAIT, FIN} state_t;

  state_t                    state_reg, state_next;
  logic [3:0]                idx_reg, idx_next;
  logic                      aw_valid_reg, aw_valid_next;
  logic                      w_valid_reg, w_valid_next;
  logic [C_ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic [C_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [31:0]               polls_reg, polls_next;
  logic [31:0]               wait_reg, wait_next;
  logic [31:0]               cycles_reg, cycles_next;
  logic [1:0]                status_reg, status_next;
  logic [31:0]               nrows_reg, ncols_a_reg, ncols_b_reg;
  logic [63:0]               in_a_reg, in_b_reg, out_c_reg;
  logic                      cmd_fire;

  function automatic logic [11:0] addr_of(input logic [3:0] idx);
    case (idx)
      4'd0:    addr_of = 12'h010;
      4'd1:    addr_of = 12'h018;
      4'd2:    addr_of = 12'h020;
      4'd3:    addr_of = 12'h028;
      4'd4:    addr_of = 12'h02c;
      4'd5:    addr_of = 12'h030;
      4'd6:    addr_of = 12'h034;
      4'd7:    addr_of = 12'h038;
      4'd8:    addr_of = 12'h03c;
      default: addr_of = 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] idx, input logic [31:0] nr,
                                          input logic [31:0] ca, input logic [31:0] cb,
                                          input logic [63:0] ia, input logic [63:0] ib,
                                          input logic [63:0] oc);
    case (idx)
      4'd0:    data_of = nr;
      4'd1:    data_of = ca;
      4'd2:    data_of = cb;
      4'd3:    data_of = ia[31:0];
      4'd4:    data_of = ia[63:32];
      4'd5:    data_of = ib[31:0];
      4'd6:    data_of = ib[63:32];
      4'd7:    data_of = oc[31:0];
      4'd8:    data_of = oc[63:32];
      default: data_of = 32'h1;
    endcase
  endfunction

  assign cmd_fire = (state_reg == IDLE) && cmd_valid;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      polls_reg    <= '0;
      wait_reg     <= '0;
      cycles_reg   <= '0;
      status_reg   <= 2'b00;
      nrows_reg    <= '0;
      ncols_a_reg  <= '0;
      ncols_b_reg  <= '0;
      in_a_reg     <= '0;
      in_b_reg     <= '0;
      out_c_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      aw_valid_reg <= aw_valid_next;
      w_valid_reg  <= w_valid_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      polls_reg    <= polls_next;
      wait_reg     <= wait_next;
      cycles_reg   <= cycles_next;
      status_reg   <= status_next;
      if (cmd_fire) begin
        nrows_reg   <= nrows_A;
        ncols_a_reg <= ncols_A;
        ncols_b_reg <= ncols_B;
        in_a_reg    <= in_A;
        in_b_reg    <= in_B;
        out_c_reg   <= out_C;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    aw_valid_next = aw_valid_reg;
    w_valid_next  = w_valid_reg;
    awaddr_next   = awaddr_reg;
    wdata_next    = wdata_reg;
    polls_next    = polls_reg;
    wait_next     = wait_reg;
    cycles_next   = cycles_reg;
    status_next   = status_reg;

    // elapsed time covers the whole polling phase, saturating
    if ((state_reg == RD || state_reg == RDATA || state_reg == WAIT) && cycles_reg != 32'hFFFF_FFFF)
      cycles_next = cycles_reg + 32'd1;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next    = WR;
          idx_next      = 4'd0;
          aw_valid_next = 1'b1;
          w_valid_next  = 1'b1;
          awaddr_next   = C_ADDR_WIDTH'(addr_of(4'd0));
          wdata_next    = C_DATA_WIDTH'(data_of(4'd0, nrows_A, ncols_A, ncols_B, in_A, in_B, out_C));
          status_next   = 2'b00;
          cycles_next   = '0;
        end
      end
      WR: begin
        if (aw_valid_reg && m_awready) aw_valid_next = 1'b0;
        if (w_valid_reg && m_wready)   w_valid_next  = 1'b0;
        if (!aw_valid_next && !w_valid_next) state_next = BRESP;
      end
      BRESP: begin
        if (m_bvalid) begin
          if (m_bresp != 2'b00) begin
            state_next  = FIN;
            status_next = 2'b01;
          end else if (idx_reg != 4'd9) begin
            idx_next      = idx_reg + 4'd1;
            state_next    = WR;
            aw_valid_next = 1'b1;
            w_valid_next  = 1'b1;
            awaddr_next   = C_ADDR_WIDTH'(addr_of(idx_reg + 4'd1));
            wdata_next    = C_DATA_WIDTH'(data_of(idx_reg + 4'd1, nrows_reg, ncols_a_reg,
                                                  ncols_b_reg, in_a_reg, in_b_reg, out_c_reg));
          end else begin
            cycles_next = '0;
            polls_next  = '0;
            state_next  = RD;
          end
        end
      end
      RD: begin
        if (m_arready) state_next = RDATA;
      end
      RDATA: begin
        if (m_rvalid) begin
          polls_next = polls_reg + 32'd1;
          // ap_done is clear-on-read, so one set bit is final
          if (m_rresp != 2'b00) begin
            state_next  = FIN;
            status_next = 2'b10;
          end else if (m_rdata[1]) begin
            state_next  = FIN;
            status_next = 2'b00;
          end else if (polls_next == 32'(C_MAX_POLLS)) begin
            state_next  = FIN;
            status_next = 2'b11;
          end else begin
            state_next = WAIT;
            wait_next  = '0;
          end
        end
      end
      WAIT: begin
        wait_next = wait_reg + 32'd1;
        if (wait_reg == 32'(C_POLL_INTERVAL - 1)) state_next = RD;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  logic unused_rdata;
  assign unused_rdata = &{1'b0, m_rdata};

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);
  assign status    = status_reg;
  assign cycles    = cycles_reg;
  assign m_awvalid = aw_valid_reg;
  assign m_awaddr  = awaddr_reg;
  assign m_wvalid  = w_valid_reg;
  assign m_wdata   = wdata_reg;
  assign m_wstrb   = '1;
  assign m_bready  = (state_reg == BRESP);
  assign m_arvalid = (state_reg == RD);
  assign m_araddr  = '0;
  assign m_rready  = (state_reg == RDATA);

endmodule

// File: tb/tb_my_matrix_multiplier_ctrl_master.sv
// Directed bench for the control master: a scripted AXI-Lite slave for the main
// instance and an always-busy slave for a short-timeout instance.
module tb_my_matrix_multiplier_ctrl_master;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] nrows_A = '0, ncols_A = '0, ncols_B = '0;
  logic [63:0] in_A = '0, in_B = '0, out_C = '0;

  // main instance
  logic        cmd_valid = 1'b0, cmd_ready, busy, done;
  logic [1:0]  status;
  logic [31:0] cycles;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [11:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  // timeout instance
  logic        t_cmd_valid = 1'b0, t_cmd_ready, t_busy, t_done;
  logic [1:0]  t_status;
  logic [31:0] t_cycles;
  logic        t_awvalid, t_awready, t_wvalid, t_wready, t_bvalid, t_bready;
  logic        t_arvalid, t_arready, t_rvalid, t_rready;
  logic [11:0] t_awaddr, t_araddr;
  logic [31:0] t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  logic [1:0]  t_bresp, t_rresp;

  my_matrix_multiplier_ctrl_master dut (
    .aclk(clk), .areset_n(areset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .nrows_A(nrows_A), .ncols_A(ncols_A), .ncols_B(ncols_B),
    .in_A(in_A), .in_B(in_B), .out_C(out_C),
    .busy(busy), .done(done), .status(status), .cycles(cycles),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  my_matrix_multiplier_ctrl_master #(.C_POLL_INTERVAL(2), .C_MAX_POLLS(4)) dut_to (
    .aclk(clk), .areset_n(areset_n), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .nrows_A(nrows_A), .ncols_A(ncols_A), .ncols_B(ncols_B),
    .in_A(in_A), .in_B(in_B), .out_C(out_C),
    .busy(t_busy), .done(t_done), .status(t_status), .cycles(t_cycles),
    .m_awvalid(t_awvalid), .m_awready(t_awready), .m_awaddr(t_awaddr),
    .m_wvalid(t_wvalid), .m_wready(t_wready), .m_wdata(t_wdata), .m_wstrb(t_wstrb),
    .m_bvalid(t_bvalid), .m_bready(t_bready), .m_bresp(t_bresp),
    .m_arvalid(t_arvalid), .m_arready(t_arready), .m_araddr(t_araddr),
    .m_rvalid(t_rvalid), .m_rready(t_rready), .m_rdata(t_rdata), .m_rresp(t_rresp)
  );

  // scripted slave for the main instance; drives on the falling edge
  int aw_delay = 0, err_write = 0, done_after = 100;
  int aw_wait = 0, wr_count = 0, start_cyc = 0;
  int stab_err = 0, order_err = 0, strb_err = 0;
  bit started = 0, aw_got = 0, w_got = 0, w_first = 0;
  bit p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
  bit prev_awvalid = 0, prev_wvalid = 0;
  logic [11:0] prev_awaddr = '0;
  logic [31:0] prev_wdata = '0;
  logic [11:0] aw_log[$];
  logic [31:0] w_log[$];
  int          ar_log[$];

  always @(negedge clk) begin
    if (!areset_n) begin
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
      aw_wait = 0; aw_got = 0; w_got = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
      prev_awvalid = 0; prev_wvalid = 0;
    end else begin
      if (p_b) m_bvalid = 0;
      if (p_r) m_rvalid = 0;
      if (p_aw) aw_got = 1;
      if (p_w) w_got = 1;
      if (p_ar) begin
        m_rvalid = 1;
        m_rresp  = 2'b00;
        m_rdata  = (started && (cyc - start_cyc >= done_after)) ? 32'h2 : 32'h0;
      end
      if (aw_got && w_got && !m_bvalid) begin
        wr_count++;
        m_bvalid = 1;
        m_bresp  = (wr_count == err_write) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
        if (wr_count == 10) begin started = 1; start_cyc = cyc; end
      end
      if (m_awvalid && prev_awvalid && m_awaddr !== prev_awaddr) stab_err++;
      if (m_wvalid && prev_wvalid && m_wdata !== prev_wdata) stab_err++;
      if (m_bready && (m_awvalid || m_wvalid)) order_err++;
      if (m_awvalid) begin m_awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin m_awready = 0; aw_wait = 0; end
      m_wready  = m_wvalid;
      m_arready = m_arvalid;
      p_aw = m_awvalid && m_awready;
      p_w  = m_wvalid && m_wready;
      p_b  = m_bvalid && m_bready;
      p_ar = m_arvalid && m_arready;
      p_r  = m_rvalid && m_rready;
      if (p_aw) aw_log.push_back(m_awaddr);
      if (p_w) begin
        w_log.push_back(m_wdata);
        if (m_wstrb !== 4'hF) strb_err++;
        if (m_awvalid && !p_aw) w_first = 1;
      end
      if (p_ar) ar_log.push_back(cyc);
      prev_awvalid = m_awvalid; prev_awaddr = m_awaddr;
      prev_wvalid  = m_wvalid;  prev_wdata  = m_wdata;
    end
  end

  // slave for the timeout instance: always ready, never reports ap_done
  int t_aw_count = 0, t_ar_count = 0;
  bit tp_aw = 0, tp_b = 0, tp_ar = 0, tp_r = 0;
  always @(negedge clk) begin
    t_awready = 1; t_wready = 1; t_arready = 1;
    t_bresp = 2'b00; t_rresp = 2'b00; t_rdata = 32'h0;
    if (!areset_n) begin
      t_bvalid = 0; t_rvalid = 0; tp_aw = 0; tp_b = 0; tp_ar = 0; tp_r = 0;
    end else begin
      if (tp_b) t_bvalid = 0;
      if (tp_r) t_rvalid = 0;
      if (tp_aw) t_bvalid = 1;
      if (tp_ar) t_rvalid = 1;
      tp_aw = t_awvalid && t_wvalid;
      tp_b  = t_bvalid && t_bready;
      tp_ar = t_arvalid;
      tp_r  = t_rvalid && t_rready;
      if (tp_aw) t_aw_count++;
      if (tp_ar) t_ar_count++;
    end
  end

  int errors = 0, checks = 0;

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete();
    wr_count = 0; started = 0; stab_err = 0; order_err = 0; strb_err = 0; w_first = 0;
  endtask

  task automatic set_args();
    nrows_A = 32'd4; ncols_A = 32'd8; ncols_B = 32'd2;
    in_A = 64'h1_0000_1000; in_B = 64'h2_0000_2000; out_C = 64'h3_0000_3000;
  endtask

  task automatic issue_cmd(input bit to_inst);
    @(negedge clk);
    if (to_inst) t_cmd_valid = 1; else cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0; t_cmd_valid = 0;
  endtask

  task automatic wait_done(input bit to_inst, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((to_inst ? t_done : done) === 1'b1) begin ok = 1; return; end
    end
  endtask

  task automatic check_sequence(input string tag);
    logic [11:0] ea [10];
    logic [31:0] ed [10];
    ea = '{12'h010, 12'h018, 12'h020, 12'h028, 12'h02c, 12'h030, 12'h034, 12'h038, 12'h03c, 12'h000};
    ed = '{nrows_A, ncols_A, ncols_B, in_A[31:0], in_A[63:32], in_B[31:0], in_B[63:32],
           out_C[31:0], out_C[63:32], 32'h1};
    checks++;
    if (aw_log.size() != 10 || w_log.size() != 10) begin
      errors++;
      $display("FAIL %s_count aw=%0d w=%0d required 10/10", tag, aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (aw_log[i] !== ea[i] || w_log[i] !== ed[i]) begin
          errors++;
          $display("FAIL %s_write%0d addr=%h data=%h required %h/%h", tag, i, aw_log[i], w_log[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (strb_err != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL %s_strb_stable strb_err=%0d stab_err=%0d required 0/0", tag, strb_err, stab_err);
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done, busy} !== 7'b0 ||
        status !== 2'b00 || cycles !== 32'd0 || m_awaddr !== 12'h0 || m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values aw=%b w=%b busy=%b done=%b status=%b cycles=%0d required all zero",
               m_awvalid, m_wvalid, busy, done, status, cycles);
    end
    #1 areset_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got=%b required 1", cmd_ready);
    end
    // mid-transaction reset while AW is stalled
    clear_logs(); set_args(); aw_delay = 50;
    issue_cmd(0);
    @(negedge clk);
    checks++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 12'h010) begin
      errors++;
      $display("FAIL reset_pre_aw awvalid=%b awaddr=%h required 1/010", m_awvalid, m_awaddr);
    end
    #2 areset_n = 0;
    #1;
    checks++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || busy !== 1'b0 || m_awaddr !== 12'h0 ||
        m_wdata !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async awvalid=%b wvalid=%b busy=%b awaddr=%h wdata=%h required 0s",
               m_awvalid, m_wvalid, busy, m_awaddr, m_wdata);
    end
    @(negedge clk);
    #1 areset_n = 1;
    aw_delay = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    ok = 1;
  endtask

  task automatic test_normal();
    bit ok, gap_ok;
    clear_logs(); set_args(); aw_delay = 0; err_write = 0; done_after = 100;
    issue_cmd(0);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL normal_busy busy=%b cmd_ready=%b required 1/0", busy, cmd_ready);
    end
    wait_done(0, 1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL normal_done_timeout done not seen within 1000 cycles");
    end
    checks++;
    if (status !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_status status=%b busy=%b required 00/1", status, busy);
    end
    checks++;
    if (cycles < 32'd100 || cycles > 32'd120) begin
      errors++;
      $display("FAIL normal_cycles got=%0d required 100..120", cycles);
    end
    gap_ok = (ar_log.size() >= 2);
    for (int i = 1; i < ar_log.size(); i++) if (ar_log[i] - ar_log[i-1] != 18) gap_ok = 0;
    checks++;
    if (!gap_ok) begin
      errors++;
      $display("FAIL normal_poll_interval polls=%0d required >=2 polls 18 cycles apart", ar_log.size());
    end
    check_sequence("normal");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || status !== 2'b00) begin
      errors++;
      $display("FAIL normal_after done=%b busy=%b cmd_ready=%b status=%b required 0/0/1/00",
               done, busy, cmd_ready, status);
    end
  endtask

  task automatic test_write_error();
    bit ok;
    clear_logs(); set_args(); aw_delay = 0; err_write = 4; done_after = 100;
    issue_cmd(0);
    wait_done(0, 500, ok);
    checks++;
    if (!ok || status !== 2'b01) begin
      errors++;
      $display("FAIL werr_status done=%b status=%b required 1/01", ok, status);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (aw_log.size() != 4 || ar_log.size() != 0) begin
      errors++;
      $display("FAIL werr_traffic aw=%0d ar=%0d required 4/0", aw_log.size(), ar_log.size());
    end
    err_write = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    t_aw_count = 0; t_ar_count = 0;
    issue_cmd(1);
    wait_done(1, 500, ok);
    checks++;
    if (!ok || t_status !== 2'b11) begin
      errors++;
      $display("FAIL timeout_status done=%b status=%b required 1/11", ok, t_status);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (t_ar_count != 4 || t_aw_count != 10) begin
      errors++;
      $display("FAIL timeout_polls ar=%0d aw=%0d required 4/10", t_ar_count, t_aw_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs(); set_args(); aw_delay = 3; done_after = 10;
    issue_cmd(0);
    wait_done(0, 1000, ok);
    checks++;
    if (!ok || status !== 2'b00) begin
      errors++;
      $display("FAIL bp_status done=%b status=%b required 1/00", ok, status);
    end
    checks++;
    if (w_first !== 1'b1 || order_err != 0) begin
      errors++;
      $display("FAIL bp_order w_first=%b order_err=%0d required 1/0", w_first, order_err);
    end
    check_sequence("bp");
    aw_delay = 0;
  endtask

  task automatic test_reset_during_poll();
    bit ok;
    clear_logs(); set_args(); done_after = 100000;
    issue_cmd(0);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (m_rready === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstpoll_reach m_rready not seen within 300 cycles");
    end
    #2 areset_n = 0;
    #1;
    checks++;
    if (m_rready !== 1'b0 || m_arvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstpoll_async rready=%b arvalid=%b busy=%b required 0/0/0", m_rready, m_arvalid, busy);
    end
    @(negedge clk);
    #1 areset_n = 1;
    clear_logs(); done_after = 5;
    nrows_A = 32'd7; ncols_A = 32'd3; ncols_B = 32'd9;
    in_A = 64'hA_0000_000A; in_B = 64'hB_0000_000B; out_C = 64'hC_0000_000C;
    issue_cmd(0);
    wait_done(0, 1000, ok);
    checks++;
    if (!ok || status !== 2'b00) begin
      errors++;
      $display("FAIL rstpoll_rerun done=%b status=%b required 1/00", ok, status);
    end
    check_sequence("rstpoll");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_write_error();
    test_timeout();
    test_backpressure();
    test_reset_during_poll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
